// File: rtl/gcd_rr_scheduler.sv
// Round-robin front end that time-shares one subtractive GCD engine between NREQ
// requesters; each result is returned tagged with the index of the requester that issued it.
module gcd_rr_scheduler #(
  parameter  int WIDTH = 16,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_z,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       id_q, id_d;
  logic [WIDTH-1:0]     x_q, x_d;
  logic [WIDTH-1:0]     y_q, y_d;
  logic [WIDTH-1:0]     z_q, z_d;

  logic [NREQ-1:0][WIDTH-1:0] a_arr, b_arr;
  logic [NREQ-1:0]      gnt;
  logic [IDW-1:0]       gnt_idx;
  logic                 gnt_found;
  logic [IDW:0]         cand;
  logic [WIDTH-1:0]     a_sel, b_sel;

  assign a_arr = req_a;
  assign b_arr = req_b;

  // Search ptr, ptr+1, ... wrapping at NREQ; the first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    gnt       = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDW-1:0];
      end
    end
    if (gnt_found) gnt[gnt_idx] = 1'b1;
  end

  assign a_sel = a_arr[gnt_idx];
  assign b_sel = b_arr[gnt_idx];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          id_d    = gnt_idx;
          ptr_d   = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
          // A zero 'a' is swapped out so the engine only ever sees y==0 as "finished".
          if (a_sel == '0) begin
            x_d = b_sel;
            y_d = '0;
          end else begin
            x_d = a_sel;
            y_d = b_sel;
          end
          state_d = RUN;
        end
      end
      RUN: begin
        if (y_q == '0) begin
          z_d     = x_q;
          state_d = DONE;
        end else if (x_q > y_q) begin
          x_d = x_q - y_q;
        end else begin
          y_d = y_q - x_q;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  assign req_ready = (state_q == IDLE && !reset) ? gnt : '0;
  assign rsp_valid = (state_q == DONE);
  assign rsp_id    = id_q;
  assign rsp_z     = z_q;
  assign busy      = (state_q != IDLE);

endmodule
